// File: rtl/regfile_wb16_if.sv
// Write-back, read and load-scoreboard signals between the pipeline control
// and the architectural register file.
interface regfile_wb16_if #(
    parameter int DATAWIDTH = 16,
    parameter int ADDRWIDTH = 4
);
    logic                 wr_en;
    logic [ADDRWIDTH-1:0] wr_addr;
    logic [DATAWIDTH-1:0] wr_data;
    logic [ADDRWIDTH-1:0] rd_addr_a;
    logic [ADDRWIDTH-1:0] rd_addr_b;
    logic [DATAWIDTH-1:0] rd_data_a;
    logic [DATAWIDTH-1:0] rd_data_b;
    logic                 lock_en;
    logic [ADDRWIDTH-1:0] lock_addr;
    logic                 busy_a;
    logic                 busy_b;
    logic                 any_busy;

    modport master (
        output wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b, lock_en, lock_addr,
        input  rd_data_a, rd_data_b, busy_a, busy_b, any_busy
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b, lock_en, lock_addr,
        output rd_data_a, rd_data_b, busy_a, busy_b, any_busy
    );
endinterface

// File: rtl/regfile_wb16.sv
// Register file with one write port and two bypassed read ports. It also keeps
// a per-register scoreboard of pending loads.
module regfile_wb16 #(
    parameter int DATAWIDTH = 16,
    parameter int ADDRWIDTH = 4,
    parameter int R0_ZERO   = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    regfile_wb16_if.slave  bus
);
    localparam int unsigned DEPTH = 2 ** ADDRWIDTH;

    logic [DATAWIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0]     pend;
    logic                 wr_ok;
    logic                 lock_ok;
    logic                 hit_a;
    logic                 hit_b;
    logic [DATAWIDTH-1:0] data_a;
    logic [DATAWIDTH-1:0] data_b;

    // Register 0 is never written, so its storage stays 0 and needs no read-side masking.
    always_comb begin
        wr_ok   = bus.wr_en   && !(R0_ZERO != 0 && bus.wr_addr   == '0);
        lock_ok = bus.lock_en && !(R0_ZERO != 0 && bus.lock_addr == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem <= '{default: '0};
        end else if (wr_ok) begin
            mem[bus.wr_addr] <= bus.wr_data;
        end
    end

    // The lock is applied after the clear, so a new load issued behind a completing write keeps the bit set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= '0;
        end else begin
            if (bus.wr_en) pend[bus.wr_addr]   <= 1'b0;
            if (lock_ok)   pend[bus.lock_addr] <= 1'b1;
        end
    end

    always_comb begin
        hit_a  = wr_ok && (bus.wr_addr == bus.rd_addr_a);
        hit_b  = wr_ok && (bus.wr_addr == bus.rd_addr_b);
        data_a = hit_a ? bus.wr_data : mem[bus.rd_addr_a];
        data_b = hit_b ? bus.wr_data : mem[bus.rd_addr_b];
    end

    always_comb begin
        bus.rd_data_a = rst_n ? data_a : '0;
        bus.rd_data_b = rst_n ? data_b : '0;
        bus.busy_a    = rst_n && pend[bus.rd_addr_a] &&
                        !(bus.wr_en && bus.wr_addr == bus.rd_addr_a);
        bus.busy_b    = rst_n && pend[bus.rd_addr_b] &&
                        !(bus.wr_en && bus.wr_addr == bus.rd_addr_b);
        bus.any_busy  = rst_n && (|pend);
    end
endmodule

// File: tb/tb_regfile_wb16.sv
// Directed bench for regfile_wb16: write/read, bypass, R0 suppression,
// scoreboard lock/clear ordering and asynchronous reset.
module tb_regfile_wb16;
    logic clk = 1'b0;
    logic rst_n;
    int   n_pass = 0;
    int   n_total = 0;

    regfile_wb16_if #(.DATAWIDTH(16), .ADDRWIDTH(4)) bus ();

    regfile_wb16 #(.DATAWIDTH(16), .ADDRWIDTH(4), .R0_ZERO(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got 0x%04h expected 0x%04h", tag, obs, exp);
    endtask

    task automatic idle();
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.lock_en = 1'b0; bus.lock_addr = '0;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        bus.rd_addr_a = 4'd5; bus.rd_addr_b = 4'd5;
        #1;
        chk("reset_rd_a", bus.rd_data_a, 16'h0000);
        chk("reset_any_busy", {15'b0, bus.any_busy}, 16'h0000);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        // write 0xBEEF to r5, then reset mid-run
        bus.wr_en = 1'b1; bus.wr_addr = 4'd5; bus.wr_data = 16'hBEEF;
        @(negedge clk); idle();
        #1 chk("r5_written", bus.rd_data_a, 16'hBEEF);
        rst_n = 1'b0;
        #1 chk("r5_in_reset", bus.rd_data_a, 16'h0000);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        #1 chk("r5_after_reset", bus.rd_data_a, 16'h0000);
        chk("any_busy_after_reset", {15'b0, bus.any_busy}, 16'h0000);

        // write/read r3, attempt to write r0
        @(negedge clk);
        bus.wr_en = 1'b1; bus.wr_addr = 4'd3; bus.wr_data = 16'h1234;
        @(negedge clk); idle(); bus.rd_addr_a = 4'd3;
        #1 chk("r3_read", bus.rd_data_a, 16'h1234);
        bus.wr_en = 1'b1; bus.wr_addr = 4'd0; bus.wr_data = 16'hFFFF; bus.rd_addr_a = 4'd0;
        #1 chk("r0_no_bypass", bus.rd_data_a, 16'h0000);
        @(negedge clk); idle();
        #1 chk("r0_stays_zero", bus.rd_data_a, 16'h0000);

        // bypass on r7
        bus.wr_en = 1'b1; bus.wr_addr = 4'd7; bus.wr_data = 16'h0001;
        @(negedge clk);
        bus.wr_data = 16'hA5A5; bus.rd_addr_a = 4'd7; bus.rd_addr_b = 4'd7;
        #1 chk("bypass_a", bus.rd_data_a, 16'hA5A5);
        chk("bypass_b", bus.rd_data_b, 16'hA5A5);
        @(negedge clk); idle();
        #1 chk("r7_stored_a", bus.rd_data_a, 16'hA5A5);
        chk("r7_stored_b", bus.rd_data_b, 16'hA5A5);

        // scoreboard on r9
        bus.lock_en = 1'b1; bus.lock_addr = 4'd9;
        @(negedge clk); idle(); bus.rd_addr_b = 4'd9;
        #1 chk("r9_busy_b", {15'b0, bus.busy_b}, 16'h0001);
        chk("r9_any_busy", {15'b0, bus.any_busy}, 16'h0001);
        bus.wr_en = 1'b1; bus.wr_addr = 4'd9; bus.wr_data = 16'h0042;
        #1 chk("r9_busy_cleared_by_wr", {15'b0, bus.busy_b}, 16'h0000);
        chk("r9_bypass_data", bus.rd_data_b, 16'h0042);
        chk("r9_any_busy_registered", {15'b0, bus.any_busy}, 16'h0001);
        @(negedge clk); idle();
        #1 chk("r9_busy_after", {15'b0, bus.busy_b}, 16'h0000);
        chk("any_busy_idle", {15'b0, bus.any_busy}, 16'h0000);

        // lock and write r4 on the same edge: lock wins
        bus.lock_en = 1'b1; bus.lock_addr = 4'd4;
        bus.wr_en = 1'b1; bus.wr_addr = 4'd4; bus.wr_data = 16'h4444;
        @(negedge clk); idle(); bus.rd_addr_a = 4'd4;
        #1 chk("r4_data", bus.rd_data_a, 16'h4444);
        chk("r4_busy", {15'b0, bus.busy_a}, 16'h0001);

        // lock r6, then lock r2 while writing r6
        bus.lock_en = 1'b1; bus.lock_addr = 4'd6;
        @(negedge clk);
        bus.lock_addr = 4'd2;
        bus.wr_en = 1'b1; bus.wr_addr = 4'd6; bus.wr_data = 16'h0606;
        @(negedge clk); idle(); bus.rd_addr_a = 4'd2; bus.rd_addr_b = 4'd6;
        #1 chk("r2_busy", {15'b0, bus.busy_a}, 16'h0001);
        chk("r6_not_busy", {15'b0, bus.busy_b}, 16'h0000);
        chk("r6_data", bus.rd_data_b, 16'h0606);

        // async reset with pending locks on r1 and r15
        bus.lock_en = 1'b1; bus.lock_addr = 4'd1;
        @(negedge clk); bus.lock_addr = 4'd15;
        @(negedge clk); idle(); bus.rd_addr_a = 4'd1; bus.rd_addr_b = 4'd15;
        #1 chk("r1_busy", {15'b0, bus.busy_a}, 16'h0001);
        chk("r15_busy", {15'b0, bus.busy_b}, 16'h0001);
        #1 rst_n = 1'b0;
        #1 chk("async_busy_a", {15'b0, bus.busy_a}, 16'h0000);
        chk("async_busy_b", {15'b0, bus.busy_b}, 16'h0000);
        chk("async_any_busy", {15'b0, bus.any_busy}, 16'h0000);
        @(negedge clk); rst_n = 1'b1;

        // lock to r0 is ignored
        @(negedge clk);
        bus.lock_en = 1'b1; bus.lock_addr = 4'd0; bus.rd_addr_a = 4'd0;
        @(negedge clk); idle();
        #1 chk("r0_lock_any_busy", {15'b0, bus.any_busy}, 16'h0000);
        chk("r0_lock_busy_a", {15'b0, bus.busy_a}, 16'h0000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/regfile_wb16.md
Name: regfile_wb16

Overview:
- Architectural register file that consumes the write-back word chosen by the 16-bit 4:1 write-back source mux (ALU result, memory load, immediate, link PC).
- Holds 16 x 16-bit registers, with one write port and two combinational read ports.
- Read ports bypass a same-cycle write.
- A per-register pending-load scoreboard lets the decode stage stall on registers whose load data has not returned.

Parameters:
- DATAWIDTH, 16, register and data width in bits.
- ADDRWIDTH, 4, register address width; depth = 2**ADDRWIDTH.
- R0_ZERO, 1, when 1 register 0 always reads 0 and ignores writes.

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- wr_en  in  1  write strobe from write-back control.
- wr_addr  in  ADDRWIDTH  destination register.
- wr_data  in  DATAWIDTH  write-back word from the source mux output.
- rd_addr_a  in  ADDRWIDTH  read port A address (Rsrc).
- rd_addr_b  in  ADDRWIDTH  read port B address (Rdest).
- rd_data_a  out  DATAWIDTH  port A data.
- rd_data_b  out  DATAWIDTH  port B data.
- lock_en  in  1  marks a register as awaiting load data.
- lock_addr  in  ADDRWIDTH  register to mark pending.
- busy_a  out  1  rd_addr_a register is pending.
- busy_b  out  1  rd_addr_b register is pending.
- any_busy  out  1  OR of all pending bits.

Behaviour:
Reset:
- rst_n low asynchronously clears all registers to 0 and all pending bits to 0.
- While in reset, rd_data_a/b = 0, busy_a/b = 0, any_busy = 0.
- Reset deassertion takes effect at the next clk edge; no write or lock issued before that edge is retained.

Write:
- On posedge clk with wr_en=1, mem[wr_addr] <= wr_data.
- When R0_ZERO=1 and wr_addr=0, the write is dropped.
- Write latency is 1 cycle into storage.

Read:
- Combinational.
- rd_data_x = wr_data when wr_en=1, wr_addr=rd_addr_x, and the address is not suppressed by R0_ZERO (write-through bypass, same cycle).
- Otherwise rd_data_x = mem[rd_addr_x].
- Register 0 reads 0 when R0_ZERO=1, regardless of bypass.
- Both ports may address the same register; both return identical data.

Scoreboard:
- One pending bit per register.
- On posedge: if lock_en, pend[lock_addr] <= 1.
- On posedge: if wr_en, pend[wr_addr] <= 0.
- Same edge, same address, lock_en and wr_en both high: lock wins and the bit ends at 1 (new load issued behind the completing write).
- Same edge, different addresses: both updates apply.
- lock to register 0 with R0_ZERO=1 is ignored; pend[0] stays 0.
- busy_x = pend[rd_addr_x] AND NOT (wr_en AND wr_addr=rd_addr_x). A completing write clears the busy flag in the same cycle, consistent with the data bypass.
- any_busy = OR of pend[] (registered state only, no bypass).

Widths: no arithmetic; all addresses are full-width, with no wrap or out-of-range cases.

Test Plan:
- Reset: rst_n=0 mid-run after writing 0xBEEF to r5, then release -> r5 reads 0x0000, any_busy=0.
- Write/read: write 0x1234 to r3, next cycle rd_addr_a=3 -> 0x1234; write 0xFFFF to r0 with R0_ZERO=1 -> r0 reads 0x0000.
- Bypass: r7=0x0001; same cycle wr_en=1, wr_addr=7, wr_data=0xA5A5, rd_addr_a=rd_addr_b=7 -> both ports 0xA5A5 combinationally; after the edge both still 0xA5A5.
- Scoreboard: lock r9, next cycle rd_addr_b=9 -> busy_b=1, any_busy=1. Write 0x0042 to r9 -> busy_b=0 and rd_data_b=0x0042 in the write cycle; pend[9]=0 after the edge.
- Lock/write collision: lock_en and wr_en both to r4 on one edge -> mem[4]=wr_data and busy stays 1. Different addresses (lock r2, write r6) -> pend[2]=1, pend[6]=0.
- Async reset with pending locks: lock r1 and r15, assert rst_n low between clock edges -> busy and any_busy drop to 0 immediately without a clock.
